bomb_round_ctrl: RTL and testbench
==================================

# bomb_round_ctrl

Game-round controller for the bomb-dismantlement game: arms a round, picks a secret wire, counts down a timer, watches the wire-cut switches and declares the round won or lost. It drives the `success` line consumed by the win display and a `fail` line for the loss display. It re-arms to idle only when a display hands back its `repeatRst` pulse. It sits between the board switches and the face/beeper display blocks.

## Interface
- `TIME_LIMIT`, default 99: countdown start value in ticks, 1..127.
- `TICK_DIV`, default 50: clock cycles per countdown tick, 1..65535.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  asynchronous level from a switch; requests arming.
- `wire_cut`  in  4  asynchronous switch levels, 1 = wire i cut.
- `repeatRst`  in  1  handback from the win/loss display, level-sensitive.
- `success`  out  1  1 while in DEFUSED.
- `fail`  out  1  1 while in EXPLODED.
- `armed`  out  1  1 while in ARMED.
- `time_left`  out  7  remaining ticks, unsigned.
- `secret_idx`  out  2  index of the current secret wire; debug/verification only.

## Operation
- Input conditioning: `start` and `wire_cut` each pass through two flops (s1, s2). `wire_cut` s2 feeds a third flop d. `cut_pulse[i] = s2[i] & ~d[i]`.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, free-running every cycle. Reset value 8'h01; never all-zero.
- States and transitions:
  - IDLE -> ARMED when `start` s2 = 1 and `wire_cut` s2 = 4'b0000.
    - On that edge: `secret_idx` <= lfsr[1:0], `time_left` <= TIME_LIMIT, tick counter <= 0.
    - If `start` is high while any wire is cut, stay in IDLE.
  - ARMED, evaluated in this priority order:
    - Any `cut_pulse` bit other than `secret_idx` -> EXPLODED. A wrong cut wins over a simultaneous correct cut.
    - `cut_pulse[secret_idx]` = 1 -> DEFUSED. A correct cut wins over timer expiry in the same cycle.
    - Tick occurs with `time_left` = 0 -> EXPLODED.
  - DEFUSED or EXPLODED -> IDLE when `repeatRst` = 1.
    - `time_left` is frozen in both states.
    - `repeatRst` is ignored in IDLE and ARMED.
- Tick counter: 16-bit; counts only in ARMED and is held at 0 elsewhere. When it reaches TICK_DIV-1 it produces a tick and wraps to 0.
- On a tick with `time_left` > 0, `time_left` decrements by 1; it never underflows.
- Outputs `success`, `fail` and `armed` are registered decodes of the state. Exactly one of them is high, or none in IDLE.
- `secret_idx` holds its value from arming until the next arming.

## Timing
- Reset values:
  - state IDLE; `success`, `fail`, `armed` = 0.
  - `time_left` = TIME_LIMIT; `secret_idx` = 0.
  - lfsr = 8'h01; all sync flops and the tick counter = 0.
- Reset mid-round (any state): immediate return to the reset values, with no wait for a clock.
- Input latency: a switch change that is stable before edge N shows up as a state/output change after edge N+2.
  - This applies to `start` arming (`start` has no d stage; the IDLE decision uses s2) and to cut detection.
- `repeatRst` latency: sampled directly, no sync (the display shares `clk`). High at edge N means IDLE after edge N.
- Countdown: after arming, the first decrement happens TICK_DIV cycles later. EXPLODED is entered at the tick following the tick that made `time_left` 0, so a full round lasts (TIME_LIMIT+1)·TICK_DIV cycles.
- A cut already present at arming cannot fire: arming requires all wires at 0. Releasing a cut switch (1->0) has no effect.

## Test plan
- Reset/arm: assert `rst_n` = 0 mid-clock -> all outputs at reset values immediately. Release, raise `start` with wires 0 -> `armed` = 1 after 3 edges and `time_left` = TIME_LIMIT.
- Defuse: TICK_DIV = 4, TIME_LIMIT = 5; arm, then cut wire `secret_idx` -> `success` = 1 and `armed` = 0 three edges later, `time_left` frozen. Pulse `repeatRst` -> IDLE next edge, `success` = 0.
- Wrong wire: arm, then cut wire (`secret_idx`+1) mod 4 -> `fail` = 1. In a second run, cut the correct and a wrong wire in the same cycle -> `fail` = 1.
- Timeout: TICK_DIV = 4, TIME_LIMIT = 5, no cuts -> `time_left` steps 5,4,3,2,1,0 every 4 cycles. `fail` = 1 exactly 24 cycles after arming.
- Boundary: a correct cut pulse coincides with the expiry tick at `time_left` = 0 -> `success` = 1. `start` high with wire 2 cut -> remains IDLE. `repeatRst` pulsed in ARMED -> ignored.
- Secret sequence: with reset lfsr 8'h01, arm at known cycle counts -> `secret_idx` matches the reference LFSR model. Over 64 rounds all four indices occur.

Source files
------------

// File: rtl/bomb_round_ctrl.sv
// Bomb-game round controller: arms a round, draws a secret wire from a free-running LFSR,
// counts the timer down and holds the win/loss result until the display returns repeatRst.
module bomb_round_ctrl #(
  parameter int unsigned TIME_LIMIT = 99,
  parameter int unsigned TICK_DIV   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] wire_cut,
  input  logic       repeatRst,
  output logic       success,
  output logic       fail,
  output logic       armed,
  output logic [6:0] time_left,
  output logic [1:0] secret_idx
);

  typedef enum logic [1:0] {StIdle, StArmed, StDefused, StExploded} state_e;

  localparam logic [6:0]  TimeInit = 7'(TIME_LIMIT);
  localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_start_s1;
  logic        r_start_s2;
  logic [3:0]  r_cut_s1;
  logic [3:0]  r_cut_s2;
  logic [3:0]  r_cut_d;
  logic [7:0]  r_lfsr;
  logic [15:0] r_tick_cnt;
  logic [6:0]  r_time_left;
  logic [1:0]  r_secret;
  logic        r_success;
  logic        r_fail;
  logic        r_armed;

  logic [3:0]  w_cut_pulse;
  logic [3:0]  w_secret_mask;
  logic        w_wrong_cut;
  logic        w_right_cut;
  logic        w_tick;
  logic        w_arm;

  assign w_cut_pulse   = r_cut_s2 & ~r_cut_d;
  assign w_secret_mask = 4'b0001 << r_secret;
  assign w_wrong_cut   = |(w_cut_pulse & ~w_secret_mask);
  assign w_right_cut   = |(w_cut_pulse & w_secret_mask);
  assign w_tick        = (r_state == StArmed) && (r_tick_cnt == TickLast);
  assign w_arm         = (r_state == StIdle) && r_start_s2 && (r_cut_s2 == 4'b0000);

  // Two-flop synchronisers; the extra cut stage turns a new cut into a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_cut_s1   <= 4'b0000;
      r_cut_s2   <= 4'b0000;
      r_cut_d    <= 4'b0000;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_cut_s1   <= wire_cut;
      r_cut_s2   <= r_cut_s1;
      r_cut_d    <= r_cut_s2;
    end
  end

  // Fibonacci LFSR, taps 8,6,5,4; runs every cycle so the secret depends on arming time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_arm) w_state_next = StArmed;
      end
      StArmed: begin
        if (w_wrong_cut) begin
          w_state_next = StExploded;
        end else if (w_right_cut) begin
          w_state_next = StDefused;
        end else if (w_tick && (r_time_left == 7'd0)) begin
          w_state_next = StExploded;
        end
      end
      StDefused, StExploded: begin
        if (repeatRst) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Status outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_success <= 1'b0;
      r_fail    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_success <= (w_state_next == StDefused);
      r_fail    <= (w_state_next == StExploded);
      r_armed   <= (w_state_next == StArmed);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt  <= 16'd0;
      r_time_left <= TimeInit;
      r_secret    <= 2'd0;
    end else begin
      if (w_arm) begin
        r_secret    <= r_lfsr[1:0];
        r_time_left <= TimeInit;
      end else if (w_tick && (r_time_left != 7'd0)) begin
        r_time_left <= r_time_left - 7'd1;
      end

      if ((r_state != StArmed) || w_tick) begin
        r_tick_cnt <= 16'd0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 16'd1;
      end
    end
  end

  assign success    = r_success;
  assign fail       = r_fail;
  assign armed      = r_armed;
  assign time_left  = r_time_left;
  assign secret_idx = r_secret;

endmodule

// File: tb/tb_bomb_round_ctrl.sv
// Self-checking bench for bomb_round_ctrl: a directed table, hand-written corner sequences and
// randomized rounds, all compared each cycle against a round-level reference model.
module tb_bomb_round_ctrl;

  localparam int TL = 5;
  localparam int TD = 4;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DEF   = 2;
  localparam int M_EXP   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] wire_cut = 4'b0000;
  logic       repeatRst = 1'b0;
  logic       success;
  logic       fail;
  logic       armed;
  logic [6:0] time_left;
  logic [1:0] secret_idx;

  bomb_round_ctrl #(
    .TIME_LIMIT(TL),
    .TICK_DIV  (TD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .wire_cut  (wire_cut),
    .repeatRst (repeatRst),
    .success   (success),
    .fail      (fail),
    .armed     (armed),
    .time_left (time_left),
    .secret_idx(secret_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: round state, cycles since arming, edges since reset, input history.
  logic [7:0] seq [255];
  int         m_state;
  int         m_cycles;
  int         m_edges;
  int         m_tl;
  int         m_secret;
  logic       h_start [3];
  logic [3:0] h_cut   [3];

  typedef struct {
    logic       st;
    logic [3:0] cut_rel;
    logic       rpt;
    logic       a;
    logic       s;
    logic       f;
    logic [6:0] tl;
  } row_t;

  row_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({armed, success, fail, time_left, secret_idx});
  endfunction

  function automatic logic [31:0] model_vec();
    return 32'({m_state == M_ARMED, m_state == M_DEF, m_state == M_EXP, 7'(m_tl), 2'(m_secret)});
  endfunction

  function automatic logic [3:0] rel_cut(input logic [3:0] rel, input int sec);
    logic [3:0] m = 4'b0000;
    for (int j = 0; j < 4; j++) if (rel[j]) m[(sec + j) % 4] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_state  = M_IDLE;
    m_cycles = 0;
    m_edges  = 0;
    m_tl     = TL;
    m_secret = 0;
    for (int i = 0; i < 3; i++) begin
      h_start[i] = 1'b0;
      h_cut[i]   = 4'b0000;
    end
  endtask

  task automatic model_edge();
    logic       s_start;
    logic [3:0] s_cut;
    logic [3:0] d_cut;
    logic [3:0] pulse;
    logic [3:0] smask;
    logic [7:0] lfsr_now;
    s_start = h_start[1];
    s_cut   = h_cut[1];
    d_cut   = h_cut[2];
    h_start[2] = h_start[1];
    h_start[1] = h_start[0];
    h_start[0] = start;
    h_cut[2]   = h_cut[1];
    h_cut[1]   = h_cut[0];
    h_cut[0]   = wire_cut;
    lfsr_now = seq[m_edges % 255];
    m_edges++;
    case (m_state)
      M_IDLE: begin
        if (s_start && (s_cut == 4'b0000)) begin
          m_state  = M_ARMED;
          m_secret = int'(lfsr_now[1:0]);
          m_cycles = 0;
          m_tl     = TL;
        end
      end
      M_ARMED: begin
        m_cycles++;
        m_tl  = (m_cycles / TD >= TL) ? 0 : TL - m_cycles / TD;
        pulse = s_cut & ~d_cut;
        smask = rel_cut(4'b0001, m_secret);
        if ((pulse & ~smask) != 4'b0000) m_state = M_EXP;
        else if ((pulse & smask) != 4'b0000) m_state = M_DEF;
        else if (m_cycles == (TL + 1) * TD) m_state = M_EXP;
      end
      default: begin
        if (repeatRst) m_state = M_IDLE;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    start     = 1'b0;
    wire_cut  = 4'b0000;
    repeatRst = 1'b0;
    #1;
    check("async reset", dut_vec(), 32'({3'b000, 7'(TL), 2'b00}));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic arm_round();
    start = 1'b1;
    for (int k = 0; k < 6 && m_state != M_ARMED; k++) step();
    start = 1'b0;
    check("armed after start", 32'(armed), 32'(1));
  endtask

  task automatic end_round();
    wire_cut  = 4'b0000;
    repeatRst = 1'b1;
    step();
    repeatRst = 1'b0;
    step();
    check("idle after repeatRst", 32'({armed, success, fail}), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] seen;
    seq[0] = 8'h01;
    for (int i = 1; i < 255; i++) seq[i] = {seq[i-1][6:0], ^(seq[i-1] & 8'hB8)};

    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 7'd5};
    tbl[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 7'd5};
    tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 7'd5};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 7'd5};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 7'd5};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 7'd5};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 7'd4};
    tbl[7]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 7'd4};
    tbl[8]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 7'd4};
    tbl[9]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 7'd4};
    tbl[10] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 7'd4};
    tbl[11] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 7'd4};
    tbl[12] = '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 7'd4};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 7'd4};

    model_reset();
    @(posedge clk);
    #1;
    check("power-on reset", dut_vec(), 32'({3'b000, 7'(TL), 2'b00}));
    @(negedge clk);
    rst_n = 1'b1;

    // Arm, ignored repeatRst, first tick, defuse, frozen timer, handback.
    for (int i = 0; i < 14; i++) begin
      start     = tbl[i].st;
      repeatRst = tbl[i].rpt;
      wire_cut  = rel_cut(tbl[i].cut_rel, m_secret);
      step();
      check($sformatf("table row %0d", i), 32'({armed, success, fail, time_left}),
            32'({tbl[i].a, tbl[i].s, tbl[i].f, tbl[i].tl}));
    end

    arm_round();
    repeat (3) step();
    do_reset();

    arm_round();
    wire_cut = rel_cut(4'b0010, m_secret);
    repeat (3) step();
    check("wrong wire", 32'({success, fail}), 32'(1));
    end_round();

    arm_round();
    wire_cut = rel_cut(4'b0011, m_secret);
    repeat (3) step();
    check("right+wrong wire", 32'({success, fail}), 32'(1));
    end_round();

    arm_round();
    for (int k = 1; k <= 24; k++) begin
      step();
      if ((k % 4 == 0) && (k <= 20)) check($sformatf("countdown k=%0d", k), 32'(time_left),
                                           32'(TL - k / 4));
      if (k == 23) check("no explosion at 23", 32'(fail), 32'(0));
      if (k == 24) check("explosion at 24", 32'({armed, fail}), 32'(1));
    end
    end_round();

    arm_round();
    for (int k = 1; k <= 24; k++) begin
      if (k == 22) wire_cut = rel_cut(4'b0001, m_secret);
      step();
    end
    check("cut at expiry wins", 32'({success, fail, time_left}), 32'({2'b10, 7'd0}));
    end_round();

    wire_cut = 4'b0100;
    start    = 1'b1;
    repeat (6) step();
    check("start with wire cut", 32'(armed), 32'(0));
    start    = 1'b0;
    wire_cut = 4'b0000;
    repeat (3) step();

    seen = 4'b0000;
    for (int r = 0; r < 64; r++) begin
      repeat ($urandom_range(0, 9)) begin
        repeatRst = 1'($urandom_range(0, 1));
        step();
      end
      repeatRst = 1'b0;
      arm_round();
      seen[secret_idx] = 1'b1;
      repeat ($urandom_range(0, 12)) begin
        repeatRst = 1'($urandom_range(0, 1));
        step();
      end
      repeatRst = 1'b0;
      wire_cut  = 4'($urandom_range(0, 15));
      for (int k = 0; k < 40 && m_state == M_ARMED; k++) step();
      check("round resolved", 32'(armed), 32'(0));
      end_round();
    end
    check("all secret indices", 32'(seen), 32'(4'hF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
